// File: rtl/nand_equiv_pkg.sv
// Shared types and helpers for the NAND equivalence checker.
package nand_equiv_pkg;

  typedef enum logic [2:0] {
    OP_AND      = 3'd0,
    OP_OR       = 3'd1,
    OP_NAND     = 3'd2,
    OP_NOR      = 3'd3,
    OP_XOR      = 3'd4,
    OP_XNOR     = 3'd5,
    OP_NAND_ALT = 3'd6,  // ~a | ~b
    OP_IMPL     = 3'd7   // ~a | b
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Number of (x, y) vectors swept for a given operand width.
  function automatic int vec_count(input int width);
    return 1 << (2 * width);
  endfunction

endpackage

// File: rtl/nand_fn_cell.sv
// One-bit structural implementation of the eight two-input functions,
// each built purely from 2-input NAND gates and selected by op.
module nand_fn_cell
  import nand_equiv_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [2:0] op,
  output logic       s
);

  logic na, nb, nab;
  logic and_s, or_s, nand_s, nor_s;
  logic xor_t1, xor_t2, xor_s, xnor_s;
  logic nanb_s, impl_s;

  // Inverters and the shared a/b NAND term
  nand g_na  (na, a, a);
  nand g_nb  (nb, b, b);
  nand g_nab (nab, a, b);

  nand g_and  (and_s, nab, nab);
  nand g_or   (or_s, na, nb);
  nand g_nand (nand_s, a, b);
  nand g_nor  (nor_s, or_s, or_s);

  // Classic four-NAND XOR
  nand g_x1  (xor_t1, a, nab);
  nand g_x2  (xor_t2, b, nab);
  nand g_xor (xor_s, xor_t1, xor_t2);
  nand g_xnr (xnor_s, xor_s, xor_s);

  // ~a | ~b has its own gate so each function keeps an independent network
  nand g_nanb (nanb_s, a, b);
  nand g_impl (impl_s, a, nb);

  // Select the network output for the requested function
  always_comb begin
    s = 1'b0;
    case (op_e'(op))
      OP_AND:      s = and_s;
      OP_OR:       s = or_s;
      OP_NAND:     s = nand_s;
      OP_NOR:      s = nor_s;
      OP_XOR:      s = xor_s;
      OP_XNOR:     s = xnor_s;
      OP_NAND_ALT: s = nanb_s;
      OP_IMPL:     s = impl_s;
      default:     s = 1'b0;
    endcase
  end

endmodule

// File: rtl/nand_equiv_checker.sv
// Sequential equivalence checker: sweeps every (x, y) pair and compares a
// NAND-only structural datapath against a behavioural expression.
// Optional macro NAND_EQUIV_FAULT_INJECT_EN adds fault_en/fault_idx, which
// force one structural output bit stuck-at-1.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; results of the last sweep held
// ST_SWEEP | one vector per cycle, counting mismatches, capturing first
// ST_DONE  | single cycle with done=1 and pass valid, then back to idle
module nand_equiv_checker
  import nand_equiv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
`ifdef NAND_EQUIV_FAULT_INJECT_EN
  input  logic               fault_en,
  input  logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] fault_idx,
`endif
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   mismatch_count,
  output logic [WIDTH-1:0]   first_x,
  output logic [WIDTH-1:0]   first_y,
  output logic               first_valid
);

  localparam int VW = 2 * WIDTH;
  localparam int CW = 2 * WIDTH + 1;
  localparam int N  = vec_count(WIDTH);

  state_e           state_q;
  logic [2:0]       op_q;
  logic [VW-1:0]    vec_q;
  logic [CW-1:0]    mcount_q;
  logic [WIDTH-1:0] fx_q, fy_q;
  logic             fv_q, busy_q, done_q, pass_q;

  logic [WIDTH-1:0] x, y;
  logic [WIDTH-1:0] struct_s, struct_f, beh_s;
  logic             mism;
  logic             last_vec;
  logic [CW-1:0]    mcount_d;
  logic [VW-1:0]    vec_d;

  assign x = vec_q[VW-1:WIDTH];
  assign y = vec_q[WIDTH-1:0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    nand_fn_cell u_cell (
      .a  (x[i]),
      .b  (y[i]),
      .op (op_q),
      .s  (struct_s[i])
    );
  end

`ifdef NAND_EQUIV_FAULT_INJECT_EN
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  // An index past the top bit shifts the mask out entirely, i.e. no fault
  always_comb begin
    struct_f = struct_s;
    if (fault_en) struct_f = struct_s | (ONE_W << fault_idx);
  end
`else
  assign struct_f = struct_s;
`endif

  // Behavioural reference for the latched function
  always_comb begin
    beh_s = '0;
    case (op_e'(op_q))
      OP_AND:      beh_s = x & y;
      OP_OR:       beh_s = x | y;
      OP_NAND:     beh_s = ~(x & y);
      OP_NOR:      beh_s = ~(x | y);
      OP_XOR:      beh_s = x ^ y;
      OP_XNOR:     beh_s = ~(x ^ y);
      OP_NAND_ALT: beh_s = ~x | ~y;
      OP_IMPL:     beh_s = ~x | y;
      default:     beh_s = '0;
    endcase
  end

  assign mism     = (state_q == ST_SWEEP) && (struct_f != beh_s);
  assign last_vec = (vec_q == VW'(N - 1));
  assign mcount_d = mcount_q + {{(CW-1){1'b0}}, mism};
  assign vec_d    = vec_q + VW'(1);

  // Sweep sequencer with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= 3'd0;
      vec_q    <= '0;
      mcount_q <= '0;
      fx_q     <= '0;
      fy_q     <= '0;
      fv_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_SWEEP;
            op_q     <= op;
            vec_q    <= '0;
            mcount_q <= '0;
            fx_q     <= '0;
            fy_q     <= '0;
            fv_q     <= 1'b0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        ST_SWEEP: begin
          mcount_q <= mcount_d;
          vec_q    <= vec_d;
          if (mism && !fv_q) begin
            fx_q <= x;
            fy_q <= y;
            fv_q <= 1'b1;
          end
          if (last_vec) begin
            // pass must include a mismatch on the final vector
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (mcount_d == '0);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign mismatch_count = mcount_q;
  assign first_x        = fx_q;
  assign first_y        = fy_q;
  assign first_valid    = fv_q;

endmodule

// File: tb/tb_nand_equiv_checker.sv
// Randomized self-checking bench for nand_equiv_checker against a
// function-table reference model.
`timescale 1ns/1ps
module tb_nand_equiv_checker;

  localparam int W    = 2;
  localparam int N    = 1 << (2 * W);
  localparam int MASK = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2:0]     op = 3'd0;
  logic           busy, done, pass, first_valid;
  logic [2*W:0]   mcount;
  logic [W-1:0]   fx, fy;

  logic           start1 = 1'b0;
  logic           busy1, done1, pass1, fv1;
  logic [2:0]     mcount1;
  logic           fx1, fy1;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef NAND_EQUIV_FAULT_INJECT_EN
  localparam int FIW = (W > 1) ? $clog2(W) : 1;
  logic           fault_en = 1'b0;
  logic [FIW-1:0] fault_idx = '0;
`endif

  always #5 clk = ~clk;

  nand_equiv_checker #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .op             (op),
`ifdef NAND_EQUIV_FAULT_INJECT_EN
    .fault_en       (fault_en),
    .fault_idx      (fault_idx),
`endif
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_count (mcount),
    .first_x        (fx),
    .first_y        (fy),
    .first_valid    (first_valid)
  );

  nand_equiv_checker #(.WIDTH(1)) dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start1),
    .op             (3'd4),
`ifdef NAND_EQUIV_FAULT_INJECT_EN
    .fault_en       (1'b0),
    .fault_idx      (1'b0),
`endif
    .busy           (busy1),
    .done           (done1),
    .pass           (pass1),
    .mismatch_count (mcount1),
    .first_x        (fx1),
    .first_y        (fy1),
    .first_valid    (fv1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Truth of each function code on W-bit operands.
  function automatic int spec_fn(input int opv, input int a, input int b);
    int r;
    case (opv)
      0: r = a & b;
      1: r = a | b;
      2: r = ~(a & b);
      3: r = ~(a | b);
      4: r = a ^ b;
      5: r = ~(a ^ b);
      6: r = ~a | ~b;
      default: r = ~a | b;
    endcase
    return r & MASK;
  endfunction

  // Expected sweep outcome: the structural side equals the function except
  // for an optional stuck-at-1 bit.
  function automatic void model(input int opv, input int fen, input int fidx,
                                output int cnt, output int ex, output int ey, output int ev);
    int good, faulty;
    cnt = 0; ex = 0; ey = 0; ev = 0;
    for (int v = 0; v < N; v++) begin
      good   = spec_fn(opv, v >> W, v & MASK);
      faulty = good;
      if (fen != 0 && fidx < W) faulty = good | (1 << fidx);
      if (faulty != good) begin
        if (ev == 0) begin
          ex = v >> W; ey = v & MASK; ev = 1;
        end
        cnt++;
      end
    end
  endfunction

  task automatic run_sweep(input int opv, input bit noise, input int fen, input int fidx);
    int cnt, ex, ey, ev;
    int busy_cnt, done_at;
    model(opv, fen, fidx, cnt, ex, ey, ev);
    @(negedge clk);
    start = 1'b1;
    op    = 3'(opv);
`ifdef NAND_EQUIV_FAULT_INJECT_EN
    fault_en  = 1'(fen);
    fault_idx = FIW'(fidx);
`endif
    busy_cnt = 0;
    done_at  = 0;
    for (int c = 1; c <= N + 8 && done_at == 0; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) done_at = c;
      else if (noise) begin
        start = 1'($urandom);
        op    = 3'($urandom);
      end
    end
    start = 1'b0;
    check_eq("done_latency", done_at, N + 1);
    check_eq("busy_cycles", busy_cnt, N);
    check_eq("busy_in_done", busy, 0);
    check_eq("pass", pass, (cnt == 0) ? 1 : 0);
    check_eq("mismatch_count", mcount, cnt);
    check_eq("first_valid", first_valid, ev);
    check_eq("first_x", fx, ex);
    check_eq("first_y", fy, ey);
    @(posedge clk); #1;
    check_eq("done_one_cycle", done, 0);
    check_eq("hold_count", mcount, cnt);
    check_eq("hold_pass", pass, (cnt == 0) ? 1 : 0);
  endtask

  initial begin
    int ndone, t1, t2, t3, d1;
    int fen, fidx;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_count", mcount, 0);
    check_eq("rst_first_x", fx, 0);
    check_eq("rst_first_y", fy, 0);
    check_eq("rst_first_valid", first_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Clean sweep with op 6
    run_sweep(6, 1'b0, 0, 0);

`ifdef NAND_EQUIV_FAULT_INJECT_EN
    run_sweep(0, 1'b0, 1, 0);
    run_sweep(1, 1'b0, 1, 1);
`endif

    // Randomized sweeps, some with start/op noise during the sweep
    for (int i = 0; i < 12; i++) begin
      fen = 0; fidx = 0;
`ifdef NAND_EQUIV_FAULT_INJECT_EN
      fen  = $urandom_range(0, 1);
      fidx = $urandom_range(0, (1 << FIW) - 1);
`endif
      run_sweep($urandom_range(0, 7), 1'($urandom_range(0, 1)), fen, fidx);
    end

    // start held high: sweeps back to back, N+2 cycles apart
`ifdef NAND_EQUIV_FAULT_INJECT_EN
    fault_en = 1'b0;
`endif
    @(negedge clk);
    start = 1'b1;
    op    = 3'($urandom);
    ndone = 0; t1 = 0; t2 = 0; t3 = 0;
    for (int c = 1; c <= 3 * (N + 2); c++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (ndone == 1) t1 = c;
        if (ndone == 2) t2 = c;
        if (ndone == 3) begin t3 = c; start = 1'b0; end
        check_eq("b2b_pass", pass, 1);
        op = 3'($urandom);
      end
    end
    start = 1'b0;
    check_eq("b2b_count", ndone, 3);
    check_eq("b2b_first", t1, N + 1);
    check_eq("b2b_period1", t2 - t1, N + 2);
    check_eq("b2b_period2", t3 - t2, N + 2);

    // Reset five cycles into a sweep aborts it with no done pulse
    @(negedge clk);
    start = 1'b1;
    op    = 3'd0;
`ifdef NAND_EQUIV_FAULT_INJECT_EN
    fault_en  = 1'b1;
    fault_idx = '0;
`endif
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check_eq("pre_rst_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_count", mcount, 0);
    check_eq("abort_first_valid", first_valid, 0);
    check_eq("abort_pass", pass, 0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef NAND_EQUIV_FAULT_INJECT_EN
    fault_en = 1'b0;
`endif
    d1 = 0;
    for (int c = 0; c < 2 * N + 4; c++) begin
      @(posedge clk); #1;
      if (done) d1++;
    end
    check_eq("abort_no_done", d1, 0);

    // WIDTH=1 instance: done five cycles after the start edge
    @(negedge clk);
    start1 = 1'b1;
    d1 = 0;
    for (int c = 1; c <= 12 && d1 == 0; c++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      if (done1) d1 = c;
    end
    check_eq("w1_done_latency", d1, 5);
    check_eq("w1_pass", pass1, 1);
    check_eq("w1_count", mcount1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
